// File: rtl/fmap_streamer_if.sv
// Pixel-stream and feature-map RAM read bundle between fmap_streamer (master) and its RAM/sink (slave).
interface fmap_streamer_if #(
    parameter int N      = 8,
    parameter int ADDR_W = 10
) ();
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [N-1:0]      mem_rdata;
    logic [N-1:0]      dout;
    logic              dout_vld;
    logic              dout_last;
    logic              dout_rdy;

    modport master (
        output mem_rd_en, mem_addr, dout, dout_vld, dout_last,
        input  mem_rdata, dout_rdy
    );

    modport slave (
        input  mem_rd_en, mem_addr, dout, dout_vld, dout_last,
        output mem_rdata, dout_rdy
    );
endinterface

// File: rtl/fmap_streamer.sv
// Streams a stored feature map raster-order, channel after channel, into a conv_unit input port.
// Define FMAP_STREAMER_PAD_EN to insert a PADDING-wide zero border around every channel on the fly.
module fmap_streamer #(
    parameter int N          = 8,
    parameter int INPUT_SIZE = 28,
    parameter int CHANNELS   = 1,
    parameter int PADDING    = 0,
    parameter int ADDR_W     = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    fmap_streamer_if.master bus,
    output logic            busy,
    output logic            done
);

`ifdef FMAP_STREAMER_PAD_EN
    localparam int PAD = PADDING;
`else
    localparam int PAD = PADDING * 0;
`endif
    localparam int P  = INPUT_SIZE + 2 * PAD;
    localparam int CW = (P > 1) ? $clog2(P) : 1;
    localparam int HW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CW-1:0] POS_LAST = CW'(P - 1);
    localparam logic [HW-1:0] CH_LAST  = HW'(CHANNELS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state;
    logic [CW-1:0]     row;
    logic [CW-1:0]     col;
    logic [HW-1:0]     ch;
    logic [ADDR_W-1:0] addr;
    logic              vld_q;
    logic              pad_q;
    logic              last_q;

    logic core;
    logic issue;
    logic px_last;
    logic frame_last;

`ifdef FMAP_STREAMER_PAD_EN
    localparam logic [CW-1:0] CORE_LO = CW'(PAD);
    localparam logic [CW-1:0] CORE_HI = CW'(PAD + INPUT_SIZE - 1);
    assign core = (row >= CORE_LO) && (row <= CORE_HI) && (col >= CORE_LO) && (col <= CORE_HI);
`else
    assign core = 1'b1;
`endif

    assign issue      = (state == S_RUN) && bus.dout_rdy && !abort;
    assign px_last    = (row == POS_LAST) && (col == POS_LAST);
    assign frame_last = px_last && (ch == CH_LAST);

    // The RAM answers one cycle after the read strobe, so the issued pixel's
    // type is registered and merged with mem_rdata on the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            row    <= '0;
            col    <= '0;
            ch     <= '0;
            addr   <= '0;
            vld_q  <= 1'b0;
            pad_q  <= 1'b0;
            last_q <= 1'b0;
        end else if (abort) begin
            state  <= S_IDLE;
            row    <= '0;
            col    <= '0;
            ch     <= '0;
            addr   <= '0;
            vld_q  <= 1'b0;
            pad_q  <= 1'b0;
            last_q <= 1'b0;
        end else begin
            vld_q  <= issue;
            pad_q  <= issue && !core;
            last_q <= issue && px_last;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_RUN;
                        row   <= '0;
                        col   <= '0;
                        ch    <= '0;
                        addr  <= '0;
                    end
                end
                S_RUN: begin
                    if (issue) begin
                        if (core) begin
                            addr <= addr + 1'b1;
                        end
                        if (col == POS_LAST) begin
                            col <= '0;
                            if (row == POS_LAST) begin
                                row <= '0;
                                ch  <= (ch == CH_LAST) ? '0 : ch + 1'b1;
                            end else begin
                                row <= row + 1'b1;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                        if (frame_last) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_rd_en = issue && core;
    assign bus.mem_addr  = addr;
    assign bus.dout_vld  = vld_q && !abort;
    assign bus.dout_last = last_q && !abort;
    assign bus.dout      = (vld_q && !pad_q && !abort) ? bus.mem_rdata : '0;
    assign busy          = (state != S_IDLE) && !abort;
    assign done          = (state == S_DONE) && !abort;

endmodule
